// File: rtl/mfb_superpacket_arbiter.sv
// Round-robin, whole-packet arbiter merging CHANNELS single-region MFB superpacket
// streams onto one registered MFB output; TX_MFB_META carries the source channel.
module mfb_superpacket_arbiter #(
  parameter int CHANNELS        = 4,
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8,
  parameter int QUOTA           = 2,
  localparam int DW  = MFB_REGION_SIZE * MFB_BLOCK_SIZE * MFB_ITEM_WIDTH,
  localparam int SPW = $clog2(MFB_REGION_SIZE),
  localparam int EPW = $clog2(MFB_REGION_SIZE * MFB_BLOCK_SIZE),
  localparam int CW  = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [CHANNELS-1:0]     CHANNEL_EN,
  input  logic [CHANNELS*DW-1:0]  RX_MFB_DATA,
  input  logic [CHANNELS*SPW-1:0] RX_MFB_SOF_POS,
  input  logic [CHANNELS*EPW-1:0] RX_MFB_EOF_POS,
  input  logic [CHANNELS-1:0]     RX_MFB_SOF,
  input  logic [CHANNELS-1:0]     RX_MFB_EOF,
  input  logic [CHANNELS-1:0]     RX_MFB_SRC_RDY,
  output logic [CHANNELS-1:0]     RX_MFB_DST_RDY,
  output logic [DW-1:0]           TX_MFB_DATA,
  output logic [CW-1:0]           TX_MFB_META,
  output logic [SPW-1:0]          TX_MFB_SOF_POS,
  output logic [EPW-1:0]          TX_MFB_EOF_POS,
  output logic                    TX_MFB_SOF,
  output logic                    TX_MFB_EOF,
  output logic                    TX_MFB_SRC_RDY,
  input  logic                    TX_MFB_DST_RDY
);

  localparam int QW = $clog2(QUOTA + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_grant, w_grant_nxt;
  logic [CW-1:0]   r_last, w_last_nxt;
  logic [QW-1:0]   r_quota, w_quota_nxt, w_quota_inc;

  logic [DW-1:0]   r_tx_data;
  logic [CW-1:0]   r_tx_meta;
  logic [SPW-1:0]  r_tx_sof_pos;
  logic [EPW-1:0]  r_tx_eof_pos;
  logic            r_tx_sof, r_tx_eof, r_tx_vld;

  logic [CHANNELS-1:0] w_req;
  logic [CW-1:0]   w_sel, w_idx;
  logic            w_sel_vld;
  logic            w_rx_rdy, w_accept, w_follow;
  logic [DW-1:0]   w_data;
  logic [SPW-1:0]  w_sof_pos;
  logic [EPW-1:0]  w_eof_pos;
  logic            w_sof, w_eof;

  assign w_req    = RX_MFB_SRC_RDY & RX_MFB_SOF & CHANNEL_EN;
  assign w_rx_rdy = !r_tx_vld || TX_MFB_DST_RDY;

  assign w_data    = RX_MFB_DATA[int'(r_grant)*DW +: DW];
  assign w_sof_pos = RX_MFB_SOF_POS[int'(r_grant)*SPW +: SPW];
  assign w_eof_pos = RX_MFB_EOF_POS[int'(r_grant)*EPW +: EPW];
  assign w_sof     = RX_MFB_SOF[r_grant];
  assign w_eof     = RX_MFB_EOF[r_grant];
  assign w_follow  = w_sof && (int'(w_sof_pos) * MFB_BLOCK_SIZE > int'(w_eof_pos));
  assign w_accept  = (r_state == BUSY) && w_rx_rdy && RX_MFB_SRC_RDY[r_grant];

  assign w_quota_inc = (r_quota == QW'(QUOTA)) ? r_quota : r_quota + 1'b1;

  // quota_cnt is only zero before the first grant after reset (every boundary
  // increments it), so that case skips "stay with last" and channel 0 wins.
  always_comb begin
    w_sel     = r_last;
    w_sel_vld = 1'b0;
    w_idx     = '0;
    if (w_req[r_last] && r_quota != '0 && r_quota < QW'(QUOTA)) begin
      w_sel_vld = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        w_idx = CW'((32'(r_last) + k) % CHANNELS);
        if (!w_sel_vld && w_req[w_idx]) begin
          w_sel     = w_idx;
          w_sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_quota_nxt = r_quota;
    case (r_state)
      IDLE: begin
        if (w_sel_vld) begin
          w_grant_nxt = w_sel;
          w_last_nxt  = w_sel;
          w_state_nxt = BUSY;
          if (w_sel != r_last) w_quota_nxt = '0;
        end
      end
      BUSY: begin
        if (w_accept && w_eof) begin
          w_quota_nxt = w_quota_inc;
          if (!w_follow) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RX_MFB_DST_RDY = '0;
    if (r_state == BUSY) RX_MFB_DST_RDY[r_grant] = w_rx_rdy;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= CW'(CHANNELS - 1);
      r_quota <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_quota <= w_quota_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tx_data    <= '0;
      r_tx_meta    <= '0;
      r_tx_sof_pos <= '0;
      r_tx_eof_pos <= '0;
      r_tx_sof     <= 1'b0;
      r_tx_eof     <= 1'b0;
      r_tx_vld     <= 1'b0;
    end else if (w_accept) begin
      r_tx_data    <= w_data;
      r_tx_meta    <= r_grant;
      r_tx_sof_pos <= w_sof_pos;
      r_tx_eof_pos <= w_eof_pos;
      r_tx_sof     <= w_sof;
      r_tx_eof     <= w_eof;
      r_tx_vld     <= 1'b1;
    end else if (TX_MFB_DST_RDY) begin
      r_tx_vld     <= 1'b0;
    end
  end

  assign TX_MFB_DATA    = r_tx_data;
  assign TX_MFB_META    = r_tx_meta;
  assign TX_MFB_SOF_POS = r_tx_sof_pos;
  assign TX_MFB_EOF_POS = r_tx_eof_pos;
  assign TX_MFB_SOF     = r_tx_sof;
  assign TX_MFB_EOF     = r_tx_eof;
  assign TX_MFB_SRC_RDY = r_tx_vld;

endmodule

// File: tb/tb_mfb_superpacket_arbiter.sv
// Scoreboard bench for mfb_superpacket_arbiter: directed per-channel packet queues,
// hand-ordered expected TX words, and a negedge monitor that checks every TX word.
module tb_mfb_superpacket_arbiter;

  localparam int CH  = 4;
  localparam int DW  = 512;
  localparam int SPW = 3;
  localparam int EPW = 6;
  localparam int CW  = 2;

  typedef struct {
    logic [DW-1:0]  data;
    logic           sof;
    logic           eof;
    logic [SPW-1:0] sp;
    logic [EPW-1:0] ep;
  } word_t;

  typedef struct {
    word_t         w;
    logic [CW-1:0] meta;
    int            gap;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [CH-1:0]     CHANNEL_EN;
  logic [CH*DW-1:0]  RX_MFB_DATA;
  logic [CH*SPW-1:0] RX_MFB_SOF_POS;
  logic [CH*EPW-1:0] RX_MFB_EOF_POS;
  logic [CH-1:0]     RX_MFB_SOF, RX_MFB_EOF, RX_MFB_SRC_RDY, RX_MFB_DST_RDY;
  logic [DW-1:0]     TX_MFB_DATA;
  logic [CW-1:0]     TX_MFB_META;
  logic [SPW-1:0]    TX_MFB_SOF_POS;
  logic [EPW-1:0]    TX_MFB_EOF_POS;
  logic              TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SRC_RDY, TX_MFB_DST_RDY;

  mfb_superpacket_arbiter #(
    .CHANNELS(CH), .MFB_REGION_SIZE(8), .MFB_BLOCK_SIZE(8), .MFB_ITEM_WIDTH(8), .QUOTA(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CHANNEL_EN(CHANNEL_EN),
    .RX_MFB_DATA(RX_MFB_DATA), .RX_MFB_SOF_POS(RX_MFB_SOF_POS), .RX_MFB_EOF_POS(RX_MFB_EOF_POS),
    .RX_MFB_SOF(RX_MFB_SOF), .RX_MFB_EOF(RX_MFB_EOF), .RX_MFB_SRC_RDY(RX_MFB_SRC_RDY),
    .RX_MFB_DST_RDY(RX_MFB_DST_RDY),
    .TX_MFB_DATA(TX_MFB_DATA), .TX_MFB_META(TX_MFB_META), .TX_MFB_SOF_POS(TX_MFB_SOF_POS),
    .TX_MFB_EOF_POS(TX_MFB_EOF_POS), .TX_MFB_SOF(TX_MFB_SOF), .TX_MFB_EOF(TX_MFB_EOF),
    .TX_MFB_SRC_RDY(TX_MFB_SRC_RDY), .TX_MFB_DST_RDY(TX_MFB_DST_RDY)
  );

  always #5 CLK = ~CLK;

  word_t chq [CH][$];
  exp_t  sb [$];
  int    ncmp = 0;
  int    nfail = 0;
  int    cyc = 0;
  int    last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic word_t mkw(input int ch, input int id, input int n,
                                input bit sof, input bit eof, input int sp, input int ep);
    word_t w;
    w.data = {16{8'(ch), 8'(id), 8'(n), 8'h5A}};
    w.sof  = sof;
    w.eof  = eof;
    w.sp   = SPW'(sp);
    w.ep   = EPW'(ep);
    return w;
  endfunction

  task automatic pkt(input int ch, input int id, input int n);
    for (int k = 0; k < n; k++)
      chq[ch].push_back(mkw(ch, id, k, k == 0, k == n - 1, 0, 7 * id + k + 1));
  endtask

  task automatic expw(input word_t w, input int meta, input int gap);
    exp_t e;
    e.w = w;
    e.meta = CW'(meta);
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic expect_pkt(input int ch, input int id, input int n, input int g0, input int gr);
    for (int k = 0; k < n; k++)
      expw(mkw(ch, id, k, k == 0, k == n - 1, 0, 7 * id + k + 1), ch, (k == 0) ? g0 : gr);
  endtask

  task automatic drive_all();
    for (int i = 0; i < CH; i++) begin
      if (chq[i].size() > 0) begin
        RX_MFB_DATA[i*DW +: DW]       = chq[i][0].data;
        RX_MFB_SOF_POS[i*SPW +: SPW]  = chq[i][0].sp;
        RX_MFB_EOF_POS[i*EPW +: EPW]  = chq[i][0].ep;
        RX_MFB_SOF[i]                 = chq[i][0].sof;
        RX_MFB_EOF[i]                 = chq[i][0].eof;
        RX_MFB_SRC_RDY[i]             = 1'b1;
      end else begin
        RX_MFB_DATA[i*DW +: DW]       = '0;
        RX_MFB_SOF_POS[i*SPW +: SPW]  = '0;
        RX_MFB_EOF_POS[i*EPW +: EPW]  = '0;
        RX_MFB_SOF[i]                 = 1'b0;
        RX_MFB_EOF[i]                 = 1'b0;
        RX_MFB_SRC_RDY[i]             = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] acc;
    @(negedge CLK);
    acc = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;
    @(posedge CLK);
    #1;
    for (int i = 0; i < CH; i++)
      if (acc[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    drive_all();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    chk("pending_at_reset", 64'(sb.size()), 64'd0);
    sb.delete();
    for (int i = 0; i < CH; i++) chq[i].delete();
    drive_all();
    chk("rst_tx_src_rdy", 64'(TX_MFB_SRC_RDY), 64'd0);
    chk("rst_rx_dst_rdy", 64'(RX_MFB_DST_RDY), 64'd0);
    chk("rst_tx_meta", 64'(TX_MFB_META), 64'd0);
    chk("rst_tx_data", TX_MFB_DATA[63:0], 64'd0);
    repeat (2) step();
    RESET = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (4) step();
  endtask

  // Monitor: every accepted TX word must match the scoreboard head; stalled words
  // must already equal the head and hold RX_MFB_DST_RDY low.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET === 1'b1 && TX_MFB_SRC_RDY === 1'b1) begin
        if (sb.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_word: got meta=%0d d=%h expected none", TX_MFB_META, TX_MFB_DATA[31:0]);
        end else begin
          e = sb[0];
          ncmp++;
          if (TX_MFB_DATA !== e.w.data || TX_MFB_META !== e.meta || TX_MFB_SOF !== e.w.sof ||
              TX_MFB_EOF !== e.w.eof || TX_MFB_SOF_POS !== e.w.sp || TX_MFB_EOF_POS !== e.w.ep) begin
            nfail++;
            $display("FAIL %s: got meta=%0d sof=%b eof=%b sp=%0d ep=%0d d=%h expected meta=%0d sof=%b eof=%b sp=%0d ep=%0d d=%h",
                     TX_MFB_DST_RDY ? "tx_word" : "tx_stall_hold",
                     TX_MFB_META, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS, TX_MFB_DATA[31:0],
                     e.meta, e.w.sof, e.w.eof, e.w.sp, e.w.ep, e.w.data[31:0]);
          end
          if (TX_MFB_DST_RDY === 1'b1) begin
            void'(sb.pop_front());
            if (e.gap != 0) chk("tx_gap", 64'(cyc - last_cyc), 64'(e.gap));
            last_cyc = cyc;
          end else begin
            chk("rx_rdy_stall", 64'(RX_MFB_DST_RDY), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat;
    RESET = 1'b0;
    CHANNEL_EN = '1;
    TX_MFB_DST_RDY = 1'b1;
    drive_all();
    @(posedge CLK);
    #1;
    do_reset();

    // Single channel 2: packets of 1, 2, 5 words; one idle cycle per boundary.
    pkt(2, 1, 1); pkt(2, 2, 2); pkt(2, 3, 5);
    drive_all();
    expect_pkt(2, 1, 1, 0, 1);
    expect_pkt(2, 2, 2, 2, 1);
    expect_pkt(2, 3, 5, 2, 1);
    wait_drain(100);

    // Round-robin with QUOTA=2, 1-word packets on all channels.
    do_reset();
    for (int id = 0; id < 4; id++)
      for (int c = 0; c < CH; c++) pkt(c, id, 1);
    drive_all();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < 2; k++)
          expect_pkt(c, r * 2 + k, 1, (r == 0 && c == 0 && k == 0) ? 0 : 2, 1);
    wait_drain(100);

    // Shared EOF/SOF word keeps channel 1 granted while channel 0 waits.
    do_reset();
    chq[1].push_back(mkw(1, 5, 0, 1'b1, 1'b0, 0, 0));
    chq[1].push_back(mkw(1, 5, 1, 1'b1, 1'b1, 2, 10));
    chq[1].push_back(mkw(1, 5, 2, 1'b0, 1'b1, 0, 5));
    drive_all();
    expw(mkw(1, 5, 0, 1'b1, 1'b0, 0, 0), 1, 0);
    expw(mkw(1, 5, 1, 1'b1, 1'b1, 2, 10), 1, 1);
    expw(mkw(1, 5, 2, 1'b0, 1'b1, 0, 5), 1, 1);
    step();
    pkt(0, 7, 1);
    drive_all();
    expect_pkt(0, 7, 1, 2, 1);
    wait_drain(100);

    // Backpressure on a 4-word packet.
    do_reset();
    pkt(0, 9, 4);
    drive_all();
    expect_pkt(0, 9, 4, 0, 0);
    pat = 12'b1111_1011_0011;
    for (int k = 0; k < 12; k++) begin
      TX_MFB_DST_RDY = pat[k];
      step();
    end
    TX_MFB_DST_RDY = 1'b1;
    wait_drain(100);

    // CHANNEL_EN[1] dropped mid-packet: packet completes, then 1 is skipped.
    do_reset();
    pkt(1, 1, 4);
    drive_all();
    expect_pkt(1, 1, 4, 0, 1);
    step();
    step();
    CHANNEL_EN[1] = 1'b0;
    pkt(1, 2, 1); pkt(2, 1, 1); pkt(3, 1, 1); pkt(0, 1, 1);
    drive_all();
    expect_pkt(2, 1, 1, 2, 1);
    expect_pkt(3, 1, 1, 2, 1);
    expect_pkt(0, 1, 1, 2, 1);
    wait_drain(100);

    // Reset during word 3 of channel 3's packet; arbitration restarts at channel 0.
    do_reset();
    CHANNEL_EN = '1;
    pkt(3, 1, 5);
    drive_all();
    expw(mkw(3, 1, 0, 1'b1, 1'b0, 0, 8), 3, 0);
    repeat (3) step();
    do_reset();
    pkt(3, 2, 1); pkt(0, 2, 1);
    drive_all();
    expect_pkt(0, 2, 1, 0, 1);
    expect_pkt(3, 2, 1, 2, 1);
    wait_drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mfb_superpacket_arbiter.md
# mfb_superpacket_arbiter

Round-robin arbiter that shares one superunpacketer instance between CHANNELS independent single-region MFB streams of superpackets. It grants a channel for whole packets only, with an optional per-channel burst quota. It merges the granted traffic onto one MFB output and tags each word with the source channel in TX_MFB_META. It sits directly in front of the superunpacketer RX port; downstream logic routes the unpacked frames back by channel ID.

## Interface
- CHANNELS, 4: number of input streams (2..16).
- MFB_REGION_SIZE, 8: blocks per word (single region; MFB_REGIONS = 1 fixed).
- MFB_BLOCK_SIZE, 8: items per block.
- MFB_ITEM_WIDTH, 8: bits per item.
- QUOTA, 2: maximum consecutive packets granted to one channel while others request (≥1).
- Derived: DW = MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH; SPW = log2(MFB_REGION_SIZE); EPW = log2(MFB_REGION_SIZE*MFB_BLOCK_SIZE); CW = max(1, log2(CHANNELS)).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- CHANNEL_EN  in  CHANNELS  per-channel grant enable (configuration).
- RX_MFB_DATA  in  CHANNELS*DW  input data, channel i at slice i.
- RX_MFB_SOF_POS  in  CHANNELS*SPW  SOF block index.
- RX_MFB_EOF_POS  in  CHANNELS*EPW  EOF item index.
- RX_MFB_SOF  in  CHANNELS  start of packet.
- RX_MFB_EOF  in  CHANNELS  end of packet.
- RX_MFB_SRC_RDY  in  CHANNELS  input valid.
- RX_MFB_DST_RDY  out  CHANNELS  input accept.
- TX_MFB_DATA  out  DW  merged data.
- TX_MFB_META  out  CW  source channel of the word.
- TX_MFB_SOF_POS  out  SPW, TX_MFB_EOF_POS  out  EPW, TX_MFB_SOF  out  1, TX_MFB_EOF  out  1  forwarded framing.
- TX_MFB_SRC_RDY  out  1  output valid.
- TX_MFB_DST_RDY  in  1  output accept.

## Operation
- FSM states: IDLE, BUSY. Registers: grant (CW), last (CW), quota_cnt (log2(QUOTA+1)), output word register.
- Request: req[i] = RX_MFB_SRC_RDY[i] & RX_MFB_SOF[i] & CHANNEL_EN[i].
- IDLE selection:
  - If req[last] and quota_cnt < QUOTA, select last.
  - Otherwise select the first requesting channel searching last+1, last+2, … (mod CHANNELS); this may wrap back to last itself.
  - When the selected channel differs from last, quota_cnt := 0.
  - On selection: grant := selected, last := selected, go to BUSY. No RX word is accepted in the IDLE cycle.
- BUSY: RX_MFB_DST_RDY[grant] = !TX_MFB_SRC_RDY | TX_MFB_DST_RDY. All other channels have DST_RDY = 0.
- Accepted word: copied into the output register, with META := grant.
- Packet end: an accepted word with EOF=1 and no following SOF counts as a boundary. "Following SOF" means SOF=1 with SOF_POS*MFB_BLOCK_SIZE > EOF_POS. At the boundary, quota_cnt += 1 (saturating at QUOTA) and the FSM returns to IDLE.
- EOF word that also carries a following SOF: this is not a boundary. The channel keeps the grant, quota_cnt += 1 (saturating), and the FSM stays in BUSY.
- CHANNEL_EN deasserted mid-packet: ignored until the boundary; the channel is then not re-selected.
- No request in IDLE: remain in IDLE; quota_cnt is held.

## Timing
- Reset (RESET=0, asynchronous) values: state=IDLE, grant=0, last=CHANNELS-1 (so channel 0 wins first), quota_cnt=0, TX_MFB_SRC_RDY=0, all RX_MFB_DST_RDY=0. TX data, META and framing registers also reset to 0.
- Latency: 1 cycle from RX accept to the word on TX.
- Arbitration overhead: one idle RX cycle per packet boundary. The output register may still drain during that cycle.
- TX holds all outputs stable while TX_MFB_SRC_RDY=1 and TX_MFB_DST_RDY=0.
- RX_MFB_DST_RDY is combinational from TX_MFB_DST_RDY and the registered state only; there is no path from RX_MFB_SRC_RDY.
- Reset asserted mid-packet: the partial packet is dropped from the arbiter. After release, arbitration restarts from channel 0.

## Test plan
- Single channel: channel 2 sends 3 packets of 1, 2 and 5 words, TX_DST_RDY=1 → TX carries 8 words unchanged, META=2 on each, 1-cycle latency, one RX bubble after each EOF.
- Round-robin with quota: CHANNELS=4, QUOTA=2, all channels continuously send 1-word packets → META sequence 0,0,1,1,2,2,3,3,0,0…
- Shared EOF/SOF word: channel 1 sends a word with EOF_POS=10, SOF=1, SOF_POS=2 while channel 0 requests → channel 1 keeps the grant until its next clean EOF, and no channel-0 word is interleaved.
- Backpressure: TX_DST_RDY toggles 1,0,0,1 during a 4-word packet → no word lost or duplicated, TX stable while stalled, RX_DST_RDY[grant]=0 in stalled cycles.
- Configuration: CHANNEL_EN[1] cleared during channel 1's word 2 of 4 → the packet completes, then channel 1 is skipped; sequence continues 2,3,0.
- Reset mid-packet: RESET=0 during word 3 of channel 3's packet → TX_SRC_RDY=0 and DST_RDY=0 immediately; after release, the first grant goes to channel 0 if it requests.
